// File: rtl/task_queue.sv
// Dual-lane in, dual-lane out task queue between decode and issue.
// Circular buffer with first-word-fall-through head/head+1 outputs and flush.
module task_queue #(
    parameter int DEPTH  = 8,
    parameter int TASK_W = 48,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_0,
    input  logic              in_valid_1,
    input  logic [TASK_W-1:0] in_task_0,
    input  logic [TASK_W-1:0] in_task_1,
    output logic              in_ready,
    input  logic              flush,
    output logic              out_valid_0,
    output logic              out_valid_1,
    output logic [TASK_W-1:0] out_task_0,
    output logic [TASK_W-1:0] out_task_1,
    input  logic [1:0]        out_take,
    output logic [CW-1:0]     count
);

    logic [TASK_W-1:0] mem [DEPTH];
    logic [AW-1:0]     head_reg, head_next, tail_reg, tail_next;
    logic [CW-1:0]     count_reg, count_next;
    logic [AW-1:0]     head_plus1, tail_plus1;
    logic [1:0]        n_enq, n_deq, take_eff;
    logic              wr_a, wr_b;
    logic [TASK_W-1:0] wdata_a;
    logic [DEPTH-1:0]  we_a, we_b;

    // Ready depends on registered occupancy only, so the producer sees no
    // combinational path from the issue side.
    assign in_ready   = (count_reg <= CW'(DEPTH - 2));
    assign head_plus1 = head_reg + AW'(1);
    assign tail_plus1 = tail_reg + AW'(1);

    // Lane 1 alone compacts down to the tail slot.
    assign wr_a    = in_ready && !flush && (in_valid_0 || in_valid_1);
    assign wr_b    = in_ready && !flush && in_valid_0 && in_valid_1;
    assign wdata_a = in_valid_0 ? in_task_0 : in_task_1;

    always_comb begin
        n_enq = 2'd0;
        if (in_ready) begin
            n_enq = {1'b0, in_valid_0} + {1'b0, in_valid_1};
        end
        take_eff = (out_take == 2'd3) ? 2'd2 : out_take;
        n_deq    = take_eff;
        if (count_reg < CW'(take_eff)) begin
            n_deq = count_reg[1:0];
        end
        head_next  = head_reg + AW'(n_deq);
        tail_next  = tail_reg + AW'(n_enq);
        count_next = count_reg + CW'(n_enq) - CW'(n_deq);
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
            assign we_a[gi] = wr_a && (tail_reg == AW'(gi));
            assign we_b[gi] = wr_b && (tail_plus1 == AW'(gi));
        end
    endgenerate

    // Storage is never cleared; validity comes from count alone.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (we_a[i]) begin
                mem[i] <= wdata_a;
            end else if (we_b[i]) begin
                mem[i] <= in_task_1;
            end
        end
    end

    assign out_task_0  = mem[head_reg];
    assign out_task_1  = mem[head_plus1];
    assign out_valid_0 = (count_reg >= CW'(1));
    assign out_valid_1 = (count_reg >= CW'(2));
    assign count       = count_reg;

endmodule

// File: tb/tb_task_queue.sv
// Self-checking bench for task_queue: directed vector table, corner-case
// sequences and randomized traffic against a queue-based reference model.
module tb_task_queue;
    localparam int DEPTH  = 8;
    localparam int TASK_W = 48;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst, flush, in_valid_0, in_valid_1, in_ready;
    logic [TASK_W-1:0] in_task_0, in_task_1, out_task_0, out_task_1;
    logic              out_valid_0, out_valid_1;
    logic [1:0]        out_take;
    logic [CW-1:0]     count;

    int checks = 0;
    int errors = 0;
    logic [TASK_W-1:0] model_q[$];

    task_queue #(.DEPTH(DEPTH), .TASK_W(TASK_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid_0(in_valid_0), .in_valid_1(in_valid_1),
        .in_task_0(in_task_0), .in_task_1(in_task_1),
        .in_ready(in_ready), .flush(flush),
        .out_valid_0(out_valid_0), .out_valid_1(out_valid_1),
        .out_task_0(out_task_0), .out_task_1(out_task_1),
        .out_take(out_take), .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [TASK_W-1:0] mk(input logic [31:0] pc);
        return {pc[15:0] ^ 16'hc3c3, pc};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: occupancy is the queue length; ready is decided from the
    // length at the start of the cycle; removals come off the front.
    task automatic model_step(input logic r, input logic f, input logic v0, input logic v1,
                              input logic [TASK_W-1:0] t0, input logic [TASK_W-1:0] t1,
                              input logic [1:0] take);
        int sz, want, nd;
        bit rdy;
        if (r || f) begin
            model_q.delete();
            return;
        end
        sz   = model_q.size();
        rdy  = (sz <= DEPTH - 2);
        want = (take == 2'd3) ? 2 : int'(take);
        nd   = (want < sz) ? want : sz;
        for (int i = 0; i < nd; i++) void'(model_q.pop_front());
        if (rdy) begin
            if (v0) model_q.push_back(t0);
            if (v1) model_q.push_back(t1);
        end
    endtask

    task automatic compare_model(input string tag);
        int sz;
        sz = model_q.size();
        check({tag, ".count"}, 64'(count), 64'(sz));
        check({tag, ".valid0"}, 64'(out_valid_0), 64'(sz >= 1));
        check({tag, ".valid1"}, 64'(out_valid_1), 64'(sz >= 2));
        check({tag, ".ready"}, 64'(in_ready), 64'(sz <= DEPTH - 2));
        if (sz >= 1) check({tag, ".task0"}, 64'(out_task_0), 64'(model_q[0]));
        if (sz >= 2) check({tag, ".task1"}, 64'(out_task_1), 64'(model_q[1]));
    endtask

    // One clock: drive, model, edge, then sample 1ns after the edge.
    task automatic step(input logic r, input logic f, input logic v0, input logic v1,
                        input logic [31:0] pc0, input logic [31:0] pc1, input logic [1:0] take,
                        input string tag);
        rst = r; flush = f; in_valid_0 = v0; in_valid_1 = v1;
        in_task_0 = mk(pc0); in_task_1 = mk(pc1); out_take = take;
        model_step(r, f, v0, v1, mk(pc0), mk(pc1), take);
        @(posedge clk);
        #1;
        compare_model(tag);
    endtask

    typedef struct {
        logic        v0, v1, fl;
        logic [31:0] pc0, pc1;
        logic [1:0]  take;
        int          e_count;
        logic        e_v0, e_v1, e_rdy;
        logic [31:0] e_pc0, e_pc1;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{1, 1, 0, 32'h00, 32'h04, 2'd0, 2, 1, 1, 1, 32'h00, 32'h04};
        vecs[1] = '{0, 1, 0, 32'h00, 32'h08, 2'd0, 3, 1, 1, 1, 32'h00, 32'h04};
        vecs[2] = '{0, 0, 0, 32'h00, 32'h00, 2'd1, 2, 1, 1, 1, 32'h04, 32'h08};
        vecs[3] = '{0, 0, 0, 32'h00, 32'h00, 2'd3, 0, 0, 0, 1, 32'h00, 32'h00};
        vecs[4] = '{0, 1, 0, 32'h00, 32'h40, 2'd2, 1, 1, 0, 1, 32'h40, 32'h00};
        vecs[5] = '{1, 0, 0, 32'h44, 32'h00, 2'd0, 2, 1, 1, 1, 32'h40, 32'h44};
        vecs[6] = '{1, 1, 0, 32'h48, 32'h4c, 2'd1, 3, 1, 1, 1, 32'h44, 32'h48};
        vecs[7] = '{1, 1, 1, 32'h50, 32'h54, 2'd1, 0, 0, 0, 1, 32'h00, 32'h00};
        vecs[8] = '{1, 1, 0, 32'h60, 32'h64, 2'd0, 2, 1, 1, 1, 32'h60, 32'h64};

        rst = 1; flush = 0; in_valid_0 = 0; in_valid_1 = 0;
        in_task_0 = '0; in_task_1 = '0; out_take = 0;
        step(1, 0, 0, 0, 0, 0, 0, "reset");
        check("reset.count", 64'(count), 0);
        check("reset.ready", 64'(in_ready), 1);
        check("reset.valid0", 64'(out_valid_0), 0);

        for (int i = 0; i < 9; i++) begin
            step(0, vecs[i].fl, vecs[i].v0, vecs[i].v1, vecs[i].pc0, vecs[i].pc1,
                 vecs[i].take, $sformatf("vec%0d", i));
            check($sformatf("vec%0d.count", i), 64'(count), 64'(vecs[i].e_count));
            check($sformatf("vec%0d.v0", i), 64'(out_valid_0), 64'(vecs[i].e_v0));
            check($sformatf("vec%0d.v1", i), 64'(out_valid_1), 64'(vecs[i].e_v1));
            check($sformatf("vec%0d.ready", i), 64'(in_ready), 64'(vecs[i].e_rdy));
            if (vecs[i].e_v0) check($sformatf("vec%0d.pc0", i), 64'(out_task_0[31:0]), 64'(vecs[i].e_pc0));
            if (vecs[i].e_v1) check($sformatf("vec%0d.pc1", i), 64'(out_task_1[31:0]), 64'(vecs[i].e_pc1));
        end

        // Fill to full, held producer ignored, then drain two.
        step(1, 0, 0, 0, 0, 0, 0, "rst2");
        for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 32'(i * 8), 32'(i * 8 + 4), 0, "fill");
        check("full.count", 64'(count), 8);
        check("full.ready", 64'(in_ready), 0);
        step(0, 0, 1, 1, 32'h100, 32'h104, 0, "full_hold");
        check("full_hold.count", 64'(count), 8);
        check("full_hold.pc0", 64'(out_task_0[31:0]), 0);
        step(0, 0, 0, 0, 0, 0, 2, "drain2");
        check("drain2.count", 64'(count), 6);
        check("drain2.ready", 64'(in_ready), 1);
        check("drain2.pc0", 64'(out_task_0[31:0]), 8);

        // Reset beats flush and enqueue on a full queue.
        step(0, 0, 1, 1, 32'h20, 32'h24, 0, "refill");
        check("refill.count", 64'(count), 8);
        step(1, 1, 1, 1, 32'h300, 32'h304, 2, "rst_full");
        check("rst_full.count", 64'(count), 0);
        check("rst_full.ready", 64'(in_ready), 1);
        check("rst_full.valid1", 64'(out_valid_1), 0);

        // Steady state at four entries across pointer wrap.
        step(0, 0, 1, 1, 32'h0, 32'h4, 0, "ss_a");
        step(0, 0, 1, 1, 32'h8, 32'hc, 0, "ss_b");
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 1, 1, 32'(16 + i * 8), 32'(20 + i * 8), 2, "ss");
            check($sformatf("ss%0d.count", i), 64'(count), 4);
            check($sformatf("ss%0d.pc0", i), 64'(out_task_0[31:0]), 64'(8 * (i + 1)));
            check($sformatf("ss%0d.pc1", i), 64'(out_task_1[31:0]), 64'(8 * (i + 1) + 4));
        end

        // Flush at five entries, then the next enqueue lands at head.
        step(0, 1, 0, 0, 0, 0, 0, "fl0");
        step(0, 0, 1, 1, 32'h0, 32'h4, 0, "f5a");
        step(0, 0, 1, 1, 32'h8, 32'hc, 0, "f5b");
        step(0, 0, 1, 0, 32'h10, 32'h0, 0, "f5c");
        check("f5.count", 64'(count), 5);
        step(0, 1, 1, 1, 32'h80, 32'h84, 1, "flush5");
        check("flush5.count", 64'(count), 0);
        check("flush5.ready", 64'(in_ready), 1);
        check("flush5.valid0", 64'(out_valid_0), 0);
        step(0, 0, 1, 0, 32'h200, 32'h0, 0, "post_flush");
        check("post_flush.pc0", 64'(out_task_0[31:0]), 32'h200);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 29) == 0),
                 1'($urandom), 1'($urandom), $urandom, $urandom,
                 2'($urandom), $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/task_queue.md
TASK_QUEUE -- requirements
Module: task_queue

Interface
REQ-001 Parameter DEPTH, default 8, number of task_t entries held; SHALL be a power of two, at least 4.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, synchronous and active-high.
REQ-004 IN_VALID_0  input  1  decode lane 0 task present.
REQ-005 IN_VALID_1  input  1  decode lane 1 task present.
REQ-006 IN_TASK_0  input  task_t  decoded task, lane 0 (older).
REQ-007 IN_TASK_1  input  task_t  decoded task, lane 1 (younger).
REQ-008 IN_READY  output  1  queue can accept up to two tasks this cycle.
REQ-009 FLUSH  input  1  discard all held tasks (branch mispredict/redirect).
REQ-010 OUT_VALID_0  output  1  head entry valid.
REQ-011 OUT_VALID_1  output  1  head+1 entry valid.
REQ-012 OUT_TASK_0  output  task_t  task at head.
REQ-013 OUT_TASK_1  output  task_t  task at head+1.
REQ-014 OUT_TAKE  input  2  number of tasks issue consumes this cycle (0, 1, 2).
REQ-015 COUNT  output  log2(DEPTH)+1  current occupancy.

Function
REQ-016 Storage SHALL be a circular buffer of DEPTH task_t entries with head pointer, tail pointer and occupancy counter, all registered.
REQ-017 IN_READY SHALL equal (COUNT <= DEPTH-2), from registered COUNT only; no combinational path from OUT_TAKE or FLUSH.
REQ-018 Enqueue SHALL occur only when IN_READY=1; lanes with IN_VALID high while IN_READY=0 SHALL be ignored (producer holds).
REQ-019 Enqueue count n_enq = IN_VALID_0 + IN_VALID_1; lane 0 written at tail, lane 1 at tail+1 if both valid.
REQ-020 IN_VALID_1=1 with IN_VALID_0=0 SHALL write IN_TASK_1 at tail (compaction); n_enq=1.
REQ-021 Tail SHALL advance by n_enq modulo DEPTH; wrap from DEPTH-1 to 0 SHALL be seamless.
REQ-022 Outputs SHALL be first-word-fall-through: OUT_TASK_0 = entry[head], OUT_TASK_1 = entry[head+1 mod DEPTH], combinational from storage.
REQ-023 OUT_VALID_0 = (COUNT >= 1); OUT_VALID_1 = (COUNT >= 2).
REQ-024 Dequeue count n_deq = min(OUT_TAKE, COUNT); OUT_TAKE=3 SHALL be treated as 2; over-take SHALL be clamped, never underflow.
REQ-025 Head SHALL advance by n_deq modulo DEPTH.
REQ-026 Simultaneous enqueue and dequeue: next COUNT = COUNT + n_enq - n_deq in same cycle; a task enqueued in cycle N SHALL first appear on outputs in cycle N+1 (latency 1, no bypass).
REQ-027 Order SHALL be preserved: tasks leave in exact program order (lane 0 before lane 1, earlier cycles first).
REQ-028 FLUSH=1 SHALL set head, tail, COUNT to 0 at next edge, overriding enqueue and dequeue in that cycle; tasks presented that cycle are discarded.
REQ-029 Storage contents need not be cleared by FLUSH or RST; only validity is defined.

Reset
REQ-030 RST=1 at edge SHALL set head=0, tail=0, COUNT=0; thereafter OUT_VALID_0=0, OUT_VALID_1=0, IN_READY=1.
REQ-031 RST SHALL take priority over FLUSH, enqueue and dequeue, including mid-operation with a full queue.
REQ-032 OUT_TASK_x values while corresponding OUT_VALID_x=0 are don't-care.

Verification
REQ-033 After reset, enqueue tasks with pc 0x00,0x04 (both lanes), OUT_TAKE=0 -> next cycle COUNT=2, OUT_VALID_0/1=1, OUT_TASK_0.pc=0x00, OUT_TASK_1.pc=0x04.
REQ-034 Fill DEPTH=8 with four dual enqueues, OUT_TAKE=0 -> COUNT=8, IN_READY=0; further IN_VALID ignored; then OUT_TAKE=2 one cycle -> COUNT=6, IN_READY=1, head pc advances by 8.
REQ-035 Steady state COUNT=4, dual enqueue with OUT_TAKE=2 for 10 cycles -> COUNT stays 4, pointers wrap, output pc sequence strictly +4 with no gap or duplicate.
REQ-036 COUNT=1, OUT_TAKE=2 -> COUNT=0, OUT_VALID_0=0 next cycle, no underflow; IN_VALID_1 only with pc 0x40 -> OUT_TASK_0.pc=0x40, OUT_VALID_1=0.
REQ-037 COUNT=5, FLUSH=1 with dual enqueue and OUT_TAKE=1 -> next cycle COUNT=0, OUT_VALID_0=0, IN_READY=1; next enqueue appears at head.
REQ-038 Full queue, RST=1 together with FLUSH and enqueue -> COUNT=0, IN_READY=1, OUT_VALID_0/1=0 next cycle.
